// File: rtl/out_ctrl_if.sv
// Output stream bundle of out_ctrl: one saturated word per beat, tagged with
// the end-of-set marker, valid/ready handshake.
interface out_ctrl_if #(
  parameter int DW = 8
);
  logic          dst_valid;
  logic [DW-1:0] dst_data;
  logic          dst_last;
  logic          dst_ready;

  modport master (
    output dst_valid,
    output dst_data,
    output dst_last,
    input  dst_ready
  );

  modport slave (
    input  dst_valid,
    input  dst_data,
    input  dst_last,
    output dst_ready
  );
endinterface

// File: rtl/out_ctrl.sv
// Output stage behind the execution controller: saturates each accumulator
// result, tags the last row of a set, buffers it and streams it downstream.
module out_ctrl #(
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int ROWS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_init,
  input  logic                 k_fin,
  input  logic signed [AW-1:0] acc_data,
  output logic                 out_busy,
  output logic                 out_fin,
  output logic                 ovf,
  out_ctrl_if.master           dst
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] a);
    logic [DW-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = a[DW-1:0];
    end
    return r;
  endfunction

  // Each entry holds {last, data}.
  logic [DW:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovf_q, ovf_d;
  logic          out_fin_q, out_fin_d;

  logic          full_s, valid_s, push_s, pop_s, row_last_s;
  logic [DW:0]   head_s;

  // Handshake decode and next-state computation.
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    valid_s    = (count_q != {CW{1'b0}});
    push_s     = k_fin & ~full_s;
    pop_s      = valid_s & dst.dst_ready;
    row_last_s = (row_q == RW'(ROWS-1));
    head_s     = mem_q[rd_ptr_q];

    if (s_init) begin
      row_d = {RW{1'b0}};
    end else if (push_s) begin
      row_d = row_last_s ? {RW{1'b0}} : row_q + RW'(1);
    end else begin
      row_d = row_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d  = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // A full FIFO drops the word even if a pop frees a slot this cycle.
    ovf_d     = ovf_q | (k_fin & full_s);
    out_fin_d = pop_s & head_s[DW];
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      row_q     <= {RW{1'b0}};
      ovf_q     <= 1'b0;
      out_fin_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_q     <= row_d;
      ovf_q     <= ovf_d;
      out_fin_q <= out_fin_d;
    end
  end

  // FIFO storage; contents are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {row_last_s, sat(acc_data)};
    end
  end

  // Head is masked while empty so the bus reads zero after reset.
  assign dst.dst_valid = valid_s;
  assign dst.dst_data  = valid_s ? head_s[DW-1:0] : {DW{1'b0}};
  assign dst.dst_last  = valid_s & head_s[DW];
  assign out_busy      = (count_q >= CW'(DEPTH-1));
  assign out_fin       = out_fin_q;
  assign ovf           = ovf_q;

endmodule

// File: doc/out_ctrl.md
# out_ctrl

Output stage directly downstream of the execution controller. Captures one accumulator result per completed j-loop (`k_fin`), saturates it to the output width, buffers it in a small FIFO and streams it out over a valid/ready interface. Generates `out_busy` (backpressure into the execution controller's `k_init` gating) and `out_fin` (set-complete pulse that releases the controller's `s_fin`).

## Interface
- `AW`, 16: accumulator input width, signed.
- `DW`, 8: output data width, signed; `DW` ≤ `AW`.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ROWS`, 4: results per set (i-loop trip count).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_init` in 1: set start pulse; clears row counter.
- `k_fin` in 1: one-cycle pulse; `acc_data` valid this cycle.
- `acc_data` in AW: signed accumulator result.
- `out_busy` out 1: do not start another j-loop.
- `out_fin` out 1: one-cycle pulse, last word of set delivered.
- `dst_valid` out 1: output word available.
- `dst_data` out DW: saturated result.
- `dst_last` out 1: `dst_data` is row `ROWS-1` of its set.
- `dst_ready` in 1: downstream accepts.
- `ovf` out 1: sticky, `k_fin` arrived with FIFO full.

## Operation
- Saturation: if `acc_data` > 2^(DW-1)-1 → 2^(DW-1)-1; if < -2^(DW-1) → -2^(DW-1); else low DW bits. Applied before the FIFO write.
- Row counter `row` (log2 ROWS bits, min 1): increments on each accepted `k_fin` and wraps from ROWS-1 to 0. Entry written when `row == ROWS-1` carries `last = 1`.
- `s_init` sets `row` to 0. If `s_init` and `k_fin` occur in the same cycle, the write uses the pre-clear `row` and `row` becomes 0. FIFO contents are untouched by `s_init`.
- FIFO:
  - Write pointer, read pointer and `count` (0..DEPTH).
  - Push on `k_fin & count != DEPTH`.
  - Pop on `dst_valid & dst_ready`.
  - Simultaneous push and pop leave `count` unchanged; this is legal even at `count == DEPTH`, because the push is evaluated against the pre-pop count and is dropped.
  - Pointers wrap modulo DEPTH.
- `k_fin` with `count == DEPTH` and no pop in the same cycle: word dropped, `row` not advanced, `ovf` set until reset.
- `out_busy = (count >= DEPTH-1)`, combinational from `count`. This reserves one slot for the single j-loop that may be in flight when busy asserts.
- `dst_valid = (count != 0)`.
- `dst_data`/`dst_last` show the head entry and stay stable while `dst_valid & !dst_ready`.
- `out_fin` is a registered output: it is 1 in the cycle after a pop whose entry has `last = 1`, otherwise 0.

## Timing
- Reset (`rst` = 0, async) values: `count` 0, pointers 0, `row` 0, `out_busy` 0, `out_fin` 0, `dst_valid` 0, `dst_data` 0 (FIFO storage need not be reset; `dst_data` is don't-care while `dst_valid` = 0), `dst_last` 0, `ovf` 0.
- Reset mid-operation discards all buffered words. Release is synchronous to `clk` at the system level.
- Latency from `k_fin` at cycle t (empty FIFO) to `dst_valid` = 1: cycle t+1. Word is poppable at t+1.
- `out_busy` follows `count` combinationally:
  - Rises in the cycle `count` reaches DEPTH-1.
  - Falls the cycle after the pop that takes `count` below DEPTH-1.
- `out_fin` is asserted at t+1 for a last-word handshake at t. Exactly one pulse per set.
- No combinational path from `dst_ready` to `dst_valid`, `out_busy` or `out_fin`.

## Test plan
- Basic set: `ROWS`=4, `dst_ready`=1, `k_fin` with `acc_data` 5, -3, 100, -100 every 10 cycles → `dst_data` 5, -3, 100, -100, one cycle after each `k_fin`; `dst_last` only on -100; `out_fin` one cycle after that handshake; `out_busy` stays 0.
- Saturation: `acc_data` 0x7FFF, 0x8000, 127, -128, 128, -129 → `dst_data` 127, -128, 127, -128, 127, -128.
- Backpressure: `dst_ready`=0, three `k_fin` → `count` 3, `out_busy`=1 from the 3rd write; 4th `k_fin` accepted (`count` 4); raise `dst_ready` → words drain in order; `out_busy` falls after 2nd pop.
- Overflow: `dst_ready`=0, five `k_fin` → 5th dropped, `ovf`=1 and stays 1; `row` not advanced; drained sequence contains only first four words.
- Full push+pop: `count`=4, `k_fin` and `dst_ready`=1 same cycle → pop occurs, push dropped, `ovf`=1, `count` 3.
- Restart/reset: two `k_fin`, then `s_init` → next four `k_fin` mark `dst_last` on the 4th; assert `rst`=0 with `count`=2 → all outputs 0 immediately, no `out_fin`.
